// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter between the CPU MEM stage and a debug loader.
// IDLE arbitrates, ISSUE drives the memory for one cycle, RESP acks and captures read data.
module dmem_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 4,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic              dbg_lock,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner
);
    localparam int WW = $clog2(MAX_WAIT + 2);
    localparam int LW = $clog2(LOCK_MAX + 2);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t            state_q, state_d;
    logic [WW-1:0]     wait_q, wait_d;
    logic [LW-1:0]     lock_q, lock_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

    logic lock_ok, dbg_wins, burst, grant_dbg, grant_cpu;

    // lock_cnt saturates at LOCK_MAX, so "not equal" is the same as "below the limit"
    assign lock_ok   = (lock_q != LW'(LOCK_MAX));
    assign dbg_wins  = dbg_req && (!cpu_req || (dbg_lock && lock_ok) || (wait_q == WW'(MAX_WAIT)));
    assign burst     = (state_q == RESP) && owner_q && dbg_lock && dbg_req && lock_ok;
    assign grant_dbg = ((state_q == IDLE) && dbg_wins) || burst;
    assign grant_cpu = (state_q == IDLE) && cpu_req && !dbg_wins;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wait_q      <= '0;
            lock_q      <= '0;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            lock_q      <= lock_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_dbg || grant_cpu) state_d = ISSUE;
            ISSUE:   state_d = RESP;
            RESP:    state_d = burst ? ISSUE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Transaction latch, fairness counters and read-data capture
    always_comb begin
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        wait_d      = wait_q;
        lock_d      = lock_q;
        if (grant_dbg) begin
            owner_d = 1'b1;
            we_d    = dbg_we;
            addr_d  = dbg_addr;
            wdata_d = dbg_wdata;
        end else if (grant_cpu) begin
            owner_d = 1'b0;
            we_d    = cpu_we;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
        end
        if (grant_dbg || !dbg_req) wait_d = '0;
        else if (grant_cpu)        wait_d = wait_q + WW'(1);
        if (grant_cpu || !dbg_lock)    lock_d = '0;
        else if (grant_dbg && lock_ok) lock_d = lock_q + LW'(1);
        if ((state_q == RESP) && !we_q) begin
            if (owner_q) dbg_rdata_d = mem_rdata;
            else         cpu_rdata_d = mem_rdata;
        end
    end

    always_comb begin
        mem_en    = (state_q == ISSUE);
        mem_we    = mem_en && we_q;
        mem_addr  = mem_en ? addr_q  : '0;
        mem_wdata = mem_en ? wdata_q : '0;
        cpu_ack   = (state_q == RESP) && !owner_q;
        dbg_ack   = (state_q == RESP) && owner_q;
        cpu_stall = cpu_req && !cpu_ack;
        cpu_rdata = cpu_rdata_q;
        dbg_rdata = dbg_rdata_q;
        owner     = owner_q;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter against a transaction-level reference model.
module tb_dmem_arbiter;
    localparam int MAX_WAIT = 4;
    localparam int LOCK_MAX = 16;

    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       lock;
    } req_t;

    logic       clk, reset;
    logic       cpu_req, cpu_we, cpu_ack, cpu_stall;
    logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic       dbg_req, dbg_we, dbg_lock, dbg_ack;
    logic [7:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic       mem_en, mem_we, owner;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_WAIT(MAX_WAIT), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory behind the arbiter
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state: one transaction in flight, issued at cycle t_iss, acked at t_iss+1
    req_t       cq[$], dq[$];
    logic [7:0] refmem [256];
    logic       gseq[$];
    int         gk[$];
    int         k, t_iss, waitc, lockc;
    bit         have, rnd, rst_req;
    logic       who, ownr;
    req_t       tx;
    logic [7:0] tx_rd, exp_crd, exp_drd;

    task automatic model_reset();
        have = 0; ownr = 1'b0; waitc = 0; lockc = 0; exp_crd = '0; exp_drd = '0;
    endtask

    function automatic req_t rand_req(input bit d);
        req_t r;
        r.we    = 1'($urandom_range(0, 1));
        r.addr  = 8'($urandom_range(0, 7));
        r.wdata = 8'($urandom);
        r.lock  = d && ($urandom_range(0, 2) == 0);
        return r;
    endfunction

    task automatic drive();
        reset     = rst_req;
        cpu_req   = (cq.size() != 0);
        cpu_we    = cpu_req ? cq[0].we    : 1'b0;
        cpu_addr  = cpu_req ? cq[0].addr  : 8'h0;
        cpu_wdata = cpu_req ? cq[0].wdata : 8'h0;
        dbg_req   = (dq.size() != 0);
        dbg_we    = dbg_req ? dq[0].we    : 1'b0;
        dbg_addr  = dbg_req ? dq[0].addr  : 8'h0;
        dbg_wdata = dbg_req ? dq[0].wdata : 8'h0;
        dbg_lock  = dbg_req ? dq[0].lock  : 1'b0;
    endtask

    task automatic grant(input logic w);
        tx = w ? dq[0] : cq[0];
        who = w; ownr = w;
        tx_rd = refmem[tx.addr];
        if (tx.we) refmem[tx.addr] = tx.wdata;
        have = 1; t_iss = k + 1;
        gseq.push_back(w); gk.push_back(k);
        if (w) begin
            waitc = 0;
            lockc = !dbg_lock ? 0 : (lockc < LOCK_MAX ? lockc + 1 : lockc);
        end else begin
            lockc = 0;
            waitc = dbg_req ? waitc + 1 : 0;
        end
    endtask

    task automatic arbitrate();
        if (dbg_req && (!cpu_req || (dbg_lock && lockc < LOCK_MAX) || waitc == MAX_WAIT)) grant(1'b1);
        else if (cpu_req) grant(1'b0);
        else begin
            waitc = 0;
            if (!dbg_lock) lockc = 0;
        end
    endtask

    // One cycle: check outputs, let requesters react, then apply the rising edge to the model
    task automatic step();
        logic iss, ack;
        @(negedge clk);
        k++;
        iss = have && (k == t_iss);
        ack = have && (k == t_iss + 1);
        chk("mem_en",    32'(mem_en),    32'(iss));
        chk("mem_we",    32'(mem_we),    32'(iss && tx.we));
        chk("mem_addr",  32'(mem_addr),  32'(iss ? tx.addr : 8'h0));
        chk("mem_wdata", 32'(mem_wdata), 32'(iss ? tx.wdata : 8'h0));
        chk("cpu_ack",   32'(cpu_ack),   32'(ack && !who));
        chk("dbg_ack",   32'(dbg_ack),   32'(ack && who));
        chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !(ack && !who)));
        chk("owner",     32'(owner),     32'(ownr));
        chk("cpu_rdata", 32'(cpu_rdata), 32'(exp_crd));
        chk("dbg_rdata", 32'(dbg_rdata), 32'(exp_drd));
        if (ack) begin
            if (who) void'(dq.pop_front());
            else     void'(cq.pop_front());
        end
        if (rnd) begin
            if (cq.size() < 2 && $urandom_range(0, 2) == 0) cq.push_back(rand_req(1'b0));
            if (dq.size() < 4 && $urandom_range(0, 2) == 0) dq.push_back(rand_req(1'b1));
        end
        drive();
        if (!reset) begin
            model_reset();
            return;
        end
        if (ack && !tx.we) begin
            if (who) exp_drd = tx_rd;
            else     exp_crd = tx_rd;
        end
        if (ack && who && dbg_req && dbg_lock && lockc < LOCK_MAX) grant(1'b1);
        else if (!have || k >= t_iss + 2) begin
            have = 0;
            arbitrate();
        end else begin
            if (!dbg_req)  waitc = 0;
            if (!dbg_lock) lockc = 0;
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((cq.size() != 0 || dq.size() != 0) && n < budget) begin
            step();
            n++;
        end
        chk("drain_timeout", 32'(cq.size() + dq.size()), 32'd0);
    endtask

    initial begin
        int idx;
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 8'((i * 3 + 2) & 8'hff);
            refmem[i] = 8'((i * 3 + 2) & 8'hff);
        end
        k = 0; t_iss = 0; rnd = 0; rst_req = 0;
        model_reset();
        drive();
        repeat (3) step();
        rst_req = 1;

        // CPU read of address 0 holding 2
        cq.push_back('{we: 1'b0, addr: 8'h00, wdata: 8'h00, lock: 1'b0});
        drain(20);
        step();
        chk("r036_rdata", 32'(cpu_rdata), 32'd2);

        // Debug write then CPU read-back
        dq.push_back('{we: 1'b1, addr: 8'h01, wdata: 8'h05, lock: 1'b0});
        drain(20);
        cq.push_back('{we: 1'b0, addr: 8'h01, wdata: 8'h00, lock: 1'b0});
        drain(20);
        step();
        chk("r037_rdata", 32'(cpu_rdata), 32'd5);

        // Starvation bound: dbg must win the fifth arbitration
        gseq.delete(); gk.delete();
        for (int i = 0; i < 8; i++) cq.push_back('{we: 1'b0, addr: 8'(i), wdata: 8'h00, lock: 1'b0});
        dq.push_back('{we: 1'b1, addr: 8'h20, wdata: 8'hA5, lock: 1'b0});
        drain(100);
        chk("w038_n", 32'(gseq.size()), 32'd9);
        idx = -1;
        foreach (gseq[i]) if (gseq[i] && idx < 0) idx = i;
        chk("w038_win", 32'(idx), 32'd4);

        // Locked burst of 20 writes against a pending CPU read
        step();
        gseq.delete(); gk.delete();
        for (int i = 0; i < 20; i++) dq.push_back('{we: 1'b1, addr: 8'(8'h40 + i), wdata: 8'(i + 1), lock: 1'b1});
        cq.push_back('{we: 1'b0, addr: 8'h41, wdata: 8'h00, lock: 1'b0});
        drain(200);
        chk("b039_n", 32'(gseq.size()), 32'd21);
        if (gseq.size() == 21) begin
            for (int i = 0; i < 21; i++) chk("b039_seq", 32'(gseq[i]), (i == 16) ? 32'd0 : 32'd1);
            for (int i = 0; i < 15; i++) chk("b039_b2b", 32'(gk[i + 1] - gk[i]), 32'd2);
        end

        // Randomized traffic
        rnd = 1;
        repeat (1500) step();
        rnd = 0;
        drain(300);
        repeat (3) step();

        // Reset during ISSUE of a CPU read aborts it; the read is re-requested afterwards
        cq.push_back('{we: 1'b0, addr: 8'h03, wdata: 8'h00, lock: 1'b0});
        step();
        step();
        chk("r040_issue", 32'(mem_en), 32'd1);
        rst_req = 0;
        reset = 1'b0;
        #1;
        chk("r040_mem_en",  32'(mem_en),    32'd0);
        chk("r040_ack",     32'(cpu_ack),   32'd0);
        chk("r040_addr",    32'(mem_addr),  32'd0);
        chk("r040_owner",   32'(owner),     32'd0);
        chk("r040_crdata",  32'(cpu_rdata), 32'd0);
        chk("r040_drdata",  32'(dbg_rdata), 32'd0);
        model_reset();
        step();
        step();
        rst_req = 1;
        drain(20);
        step();
        chk("r040_reread", 32'(cpu_rdata), 32'(refmem[3]));
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
